// File: rtl/seg_bcd_reader_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment bus reader.
//   seg_state_t          : frame assembly FSM states
//   SEG_0 .. SEG_9       : active-high a..g patterns (bit6=a .. bit0=g)
//   SEG_BLANK            : all segments off
//   BCD_BLANK/BCD_INVALID: nibbles reported for a blank or illegal pattern
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } seg_state_t;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_INVALID = 4'hE;

endpackage

// File: rtl/seg_bcd_reader_decoder.sv
// -----------------------------------------------------------------------------
// seg_pattern_decoder
// Combinational decode of one active-low segment byte back to a BCD nibble.
//   i_seg_n   [7:0] : active-low segments, bit7=a .. bit1=g, bit0=dp
//   o_nibble  [3:0] : decoded digit, BCD_BLANK when dark, BCD_INVALID if illegal
//   o_dp            : decimal point, active-high, independent of a..g
//   o_blank         : all of a..g off
//   o_invalid       : a..g pattern is neither a digit nor blank
// -----------------------------------------------------------------------------
module seg_pattern_decoder
  import seg_pkg::*;
(
  input  logic [7:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_dp,
  output logic       o_blank,
  output logic       o_invalid
);

  logic [6:0] w_act;

  // Invert to active-high and map the a..g pattern onto a nibble.
  always_comb begin
    w_act     = ~i_seg_n[7:1];
    o_dp      = ~i_seg_n[0];
    o_nibble  = BCD_INVALID;
    o_blank   = 1'b0;
    o_invalid = 1'b0;
    case (w_act)
      SEG_0:     o_nibble = 4'd0;
      SEG_1:     o_nibble = 4'd1;
      SEG_2:     o_nibble = 4'd2;
      SEG_3:     o_nibble = 4'd3;
      SEG_4:     o_nibble = 4'd4;
      SEG_5:     o_nibble = 4'd5;
      SEG_6:     o_nibble = 4'd6;
      SEG_7:     o_nibble = 4'd7;
      SEG_8:     o_nibble = 4'd8;
      SEG_9:     o_nibble = 4'd9;
      SEG_BLANK: begin
        o_nibble = BCD_BLANK;
        o_blank  = 1'b1;
      end
      default: begin
        o_nibble  = BCD_INVALID;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_bcd_reader.sv
// -----------------------------------------------------------------------------
// seg_bcd_reader
// Recovers BCD digits from a multiplexed active-low seven-segment bus and
// presents each complete multi-digit frame on a valid/ready interface.
//   clk, rst_n        : clock, asynchronous active-low reset
//   seg_n [7:0]       : active-low segments (a..g, dp), asynchronous to clk
//   dig_en_n [D-1:0]  : active-low one-hot digit strobes, asynchronous to clk
//   out_bcd [4D-1:0]  : frame nibbles, digit i at [4i+3:4i]
//   out_dp [D-1:0]    : decimal point per digit
//   out_err_mask      : per-digit illegal-pattern flag; out_err is its OR
//   out_valid/ready   : frame handshake
// -----------------------------------------------------------------------------
module seg_bcd_reader
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_en_n,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_dp,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != {DIGITS{1'b0}}) &&
           ((v & (v - DIGITS'(1))) == {DIGITS{1'b0}});
  endfunction

  logic [7:0]          r_seg_s1, r_seg_s2, r_seg_prev;
  logic [DIGITS-1:0]   r_dig_s1, r_dig_s2, r_dig_prev;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_slot_bcd;
  logic [DIGITS-1:0]   r_slot_dp;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   r_cap_mask;
  seg_state_t          r_state;
  logic [4*DIGITS-1:0] r_out_bcd;
  logic [DIGITS-1:0]   r_out_dp;
  logic [DIGITS-1:0]   r_out_err_mask;
  logic                r_out_err;
  logic                r_out_valid;

  logic [DIGITS-1:0]   w_strobe;
  logic                w_stable;
  logic                w_capture;
  logic                w_frame_full;
  logic [3:0]          w_nibble;
  logic                w_dp;
  logic                w_blank;
  logic                w_invalid;
  logic                w_seg_err;
  seg_state_t          w_state_next;
  logic                w_load;

  // Two-flop synchronisers; idle value is all-ones (nothing driven).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= 8'hFF;
      r_seg_s2   <= 8'hFF;
      r_seg_prev <= 8'hFF;
      r_dig_s1   <= {DIGITS{1'b1}};
      r_dig_s2   <= {DIGITS{1'b1}};
      r_dig_prev <= {DIGITS{1'b1}};
    end else begin
      r_seg_s1   <= seg_n;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= dig_en_n;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;
    end
  end

  seg_pattern_decoder u_dec (
    .i_seg_n   (r_seg_s2),
    .o_nibble  (w_nibble),
    .o_dp      (w_dp),
    .o_blank   (w_blank),
    .o_invalid (w_invalid)
  );

  // Stability qualification and single-cycle capture strobe.
  always_comb begin
    w_strobe  = ~r_dig_s2;
    w_stable  = (r_seg_s2 == r_seg_prev) && (r_dig_s2 == r_dig_prev) &&
                is_onehot(w_strobe);
    // Fire only on the transition into saturation, so a held digit is
    // captured once rather than every cycle.
    w_capture = w_stable && (r_cnt == CNT_FIRE);
    // A dark digit is a legal blank, never an error.
    w_seg_err = w_invalid & ~w_blank;
    w_frame_full = &r_cap_mask;
  end

  // Saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (!w_stable) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Slot storage: the newest capture of a digit overwrites its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_bcd <= {(4*DIGITS){1'b0}};
      r_slot_dp  <= {DIGITS{1'b0}};
      r_slot_err <= {DIGITS{1'b0}};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capture && w_strobe[i]) begin
          r_slot_bcd[4*i +: 4] <= w_nibble;
          r_slot_dp[i]         <= w_dp;
          r_slot_err[i]        <= w_seg_err;
        end
      end
    end
  end

  // Next-state and load decision for frame hand-off.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_frame_full) begin
          w_load       = 1'b1;
          w_state_next = PRESENT;
        end else begin
          w_state_next = COLLECT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (w_frame_full) begin
            // Back-to-back frame: reload and keep valid asserted.
            w_load       = 1'b1;
            w_state_next = PRESENT;
          end else begin
            w_state_next = COLLECT;
          end
        end else begin
          // Held frame waits in the slots until the consumer is ready.
          w_state_next = PRESENT;
        end
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Captured-digit mask; a capture on the load cycle starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_mask <= {DIGITS{1'b0}};
    end else if (w_load) begin
      r_cap_mask <= w_capture ? w_strobe : {DIGITS{1'b0}};
    end else if (w_capture) begin
      r_cap_mask <= r_cap_mask | w_strobe;
    end
  end

  // Registered frame outputs, updated only when a frame is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_bcd      <= {(4*DIGITS){1'b0}};
      r_out_dp       <= {DIGITS{1'b0}};
      r_out_err_mask <= {DIGITS{1'b0}};
      r_out_err      <= 1'b0;
      r_out_valid    <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == PRESENT);
      if (w_load) begin
        r_out_bcd      <= r_slot_bcd;
        r_out_dp       <= r_slot_dp;
        r_out_err_mask <= r_slot_err;
        r_out_err      <= |r_slot_err;
      end
    end
  end

  assign out_bcd      = r_out_bcd;
  assign out_dp       = r_out_dp;
  assign out_err_mask = r_out_err_mask;
  assign out_err      = r_out_err;
  assign out_valid    = r_out_valid;

endmodule

// File: tb/tb_seg_bcd_reader.sv
// -----------------------------------------------------------------------------
// tb_seg_bcd_reader
// Directed bench: table of whole frames with expected decoded outputs, plus
// hand-written sequences for glitch filtering, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_seg_bcd_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_n;
  logic [3:0]  dig_en_n;
  logic [15:0] out_bcd;
  logic [3:0]  out_dp;
  logic [3:0]  out_err_mask;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  seg_bcd_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .dig_en_n     (dig_en_n),
    .out_bcd      (out_bcd),
    .out_dp       (out_dp),
    .out_err_mask (out_err_mask),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // seg holds the active-low byte for digit i at [8i+7:8i].
  typedef struct {
    logic [31:0] seg;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  em;
  } vec_t;

  vec_t vecs [5];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int rise_cyc = -1;
  int d3_start = 0;
  logic prev_valid = 1'b0;
  logic [15:0] snap_bcd;
  logic [3:0]  snap_dp;
  logic [3:0]  snap_em;
  logic        snap_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; observe outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (out_valid === 1'b1) begin
      n_valid++;
      snap_bcd = out_bcd;
      snap_dp  = out_dp;
      snap_em  = out_err_mask;
      snap_err = out_err;
      if (!prev_valid) rise_cyc = cyc;
    end
    prev_valid = out_valid;
  endtask

  task automatic drive(input logic [7:0] s, input logic [3:0] d, input int n);
    seg_n    = s;
    dig_en_n = d;
    repeat (n) step();
  endtask

  task automatic send_digit(input logic [31:0] frame, input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    drive(frame[8*i +: 8], ~one, 8);
  endtask

  task automatic send_frame(input logic [31:0] frame);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) d3_start = cyc;
      send_digit(frame, i);
    end
  endtask

  task automatic check_snap(input string tag, input vec_t v);
    check({tag, " valid pulses"}, n_valid, 1);
    check({tag, " bcd"}, snap_bcd, v.bcd);
    check({tag, " dp"}, snap_dp, v.dp);
    check({tag, " err_mask"}, snap_em, v.em);
    check({tag, " err"}, snap_err, |v.em);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{seg: 32'h0D03099F, bcd: 16'h3091, dp: 4'b0000, em: 4'b0000};
    vecs[1] = '{seg: 32'h9F00FF7F, bcd: 16'h18FE, dp: 4'b0100, em: 4'b0001};
    vecs[2] = '{seg: 32'h1F404999, bcd: 16'h7654, dp: 4'b0100, em: 4'b0000};
    vecs[3] = '{seg: 32'hFE490125, bcd: 16'hF582, dp: 4'b1000, em: 4'b0000};
    vecs[4] = '{seg: 32'h090DFD03, bcd: 16'h93E0, dp: 4'b0000, em: 4'b0010};

    // Reset state.
    rst_n     = 1'b0;
    seg_n     = 8'hFF;
    dig_en_n  = 4'hF;
    out_ready = 1'b1;
    #2;
    check("reset valid", out_valid, 0);
    check("reset bcd", out_bcd, 0);
    check("reset dp", out_dp, 0);
    check("reset err_mask", out_err_mask, 0);
    check("reset err", out_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames with out_ready held high.
    for (int v = 0; v < 5; v++) begin
      n_valid  = 0;
      rise_cyc = -1;
      send_frame(vecs[v].seg);
      drive(8'hFF, 4'hF, 6);
      check_snap($sformatf("vec%0d", v), vecs[v]);
      if (v == 0) begin
        lat = rise_cyc - d3_start;
        checks++;
        if (lat < 2 + STABLE + 1 || lat > 2 + STABLE + 3) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, 2 + STABLE + 1, 2 + STABLE + 3);
        end
      end
    end

    // Glitch filter: short holds and a two-hot strobe capture nothing.
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] one;
      one = 4'b0001 << i;
      drive(vecs[0].seg[8*i +: 8], ~one, STABLE - 1);
    end
    drive(8'h9F, 4'b1100, 8);
    drive(8'hFF, 4'hF, 10);
    check("glitch no valid", n_valid, 0);
    // Only three real digits: the mask must still be missing digit 3.
    for (int i = 0; i < 3; i++) send_digit(vecs[1].seg, i);
    drive(8'hFF, 4'hF, 10);
    check("glitch mask partial", n_valid, 0);
    send_digit(vecs[1].seg, 3);
    drive(8'hFF, 4'hF, 6);
    check_snap("post-glitch", vecs[1]);

    // Backpressure: a second frame waits behind the presented one.
    out_ready = 1'b0;
    send_frame(vecs[0].seg);
    drive(8'hFF, 4'hF, 4);
    check("bp first valid", out_valid, 1);
    check("bp first bcd", out_bcd, 16'h3091);
    send_frame(vecs[2].seg);
    drive(8'hFF, 4'hF, 6);
    check("bp held valid", out_valid, 1);
    check("bp held bcd", out_bcd, 16'h3091);
    check("bp held dp", out_dp, 4'b0000);
    out_ready = 1'b1;
    step();
    check("bp reload valid", out_valid, 1);
    check("bp reload bcd", out_bcd, 16'h7654);
    check("bp reload dp", out_dp, 4'b0100);
    out_ready = 1'b0;
    step();
    step();
    check("bp stay valid", out_valid, 1);
    check("bp stay bcd", out_bcd, 16'h7654);
    out_ready = 1'b1;
    step();
    step();
    check("bp drain valid", out_valid, 0);

    // Reset mid-frame after two digits of the next frame.
    out_ready = 1'b0;
    send_frame(vecs[0].seg);
    drive(8'hFF, 4'hF, 4);
    check("pre-reset valid", out_valid, 1);
    drive(8'h01, 4'b1110, 8);
    drive(8'h01, 4'b1101, 8);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    seg_n    = 8'hFF;
    dig_en_n = 4'hF;
    #1;
    check("midreset valid", out_valid, 0);
    check("midreset bcd", out_bcd, 0);
    check("midreset err", out_err, 0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    prev_valid = 1'b0;
    out_ready  = 1'b1;
    n_valid    = 0;
    // Digits 0 and 1 captured before reset must not count toward this frame.
    drive(8'h01, 4'b1011, 8);
    drive(8'h01, 4'b0111, 8);
    drive(8'hFF, 4'hF, 10);
    check("resync no stale frame", n_valid, 0);
    drive(8'h01, 4'b1110, 8);
    drive(8'h01, 4'b1101, 8);
    drive(8'hFF, 4'hF, 10);
    check("resync valid pulses", n_valid, 1);
    check("resync bcd", snap_bcd, 16'h8888);
    check("resync err_mask", snap_em, 0);
    check("resync dp", snap_dp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
